// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate per clock over a circular
// sample history and a run-time-writable coefficient bank.
// The multiplier output is registered, so each computation spends N_TAPS product
// cycles plus one drain cycle in MAC before the result appears in OUT.
module fir_serial_mac #(
  parameter int unsigned N_TAPS    = 100,
  parameter int unsigned ACC_W     = 72,
  parameter int unsigned OUT_SHIFT = 0,
  localparam int unsigned AW       = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [31:0]  x_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [31:0]  y_out,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic signed [31:0]  coef_data,
  output logic                busy
);

  localparam logic [AW:0]   NT      = (AW + 1)'(N_TAPS);
  // N_TAPS modulo 2^AW: adding it wraps a negative read index back into range
  localparam logic [AW-1:0] NT_LO   = AW'(N_TAPS);
  localparam logic [AW-1:0] WP_LAST = AW'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sd2147483647);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-64'sd2147483648);

  typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

  state_e                   state;
  logic signed [31:0]       hist [N_TAPS];
  logic signed [31:0]       h    [N_TAPS];
  logic [AW-1:0]            wp;
  logic [AW-1:0]            base;
  logic [AW:0]              k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [63:0]       prod;
  logic                     prod_vld;

  logic [AW-1:0]            tap;
  logic [AW-1:0]            rd_idx;
  logic signed [31:0]       h_rd;
  logic signed [31:0]       x_rd;
  logic signed [63:0]       prod_d;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [31:0]       y_sat;
  logic                     accept;

  assign accept = (state == StIdle) && in_valid;

  // Tap/read address generation; the drain cycle (k == N_TAPS) parks on index 0.
  always_comb begin
    tap    = '0;
    rd_idx = '0;
    if (k < NT) begin
      tap = k[AW-1:0];
      if (base >= tap) rd_idx = base - tap;
      else             rd_idx = base + NT_LO - tap;
    end
  end

  // Full-precision product, accumulate, shift and saturate.
  always_comb begin
    h_rd      = h[tap];
    x_rd      = hist[rd_idx];
    prod_d    = 64'(h_rd) * 64'(x_rd);
    acc_sum   = acc + ACC_W'(prod);
    acc_shift = acc_sum >>> OUT_SHIFT;
    if (acc_shift > SAT_MAX)      y_sat = 32'sh7fff_ffff;
    else if (acc_shift < SAT_MIN) y_sat = 32'sh8000_0000;
    else                          y_sat = acc_shift[31:0];
  end

  // Control FSM with registered handshake/status outputs and the MAC datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      busy      <= 1'b0;
      wp        <= '0;
      base      <= '0;
      k         <= '0;
      acc       <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            base     <= wp;
            wp       <= (wp == WP_LAST) ? '0 : wp + AW'(1);
            acc      <= '0;
            k        <= '0;
            prod_vld <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= StMac;
          end
        end
        StMac: begin
          if (prod_vld) acc <= acc_sum;
          if (k < NT) begin
            prod     <= prod_d;
            prod_vld <= 1'b1;
            k        <= k + (AW + 1)'(1);
          end else begin
            // Drain cycle: the last product joins the sum on its way to y_out.
            y_out     <= y_sat;
            out_valid <= 1'b1;
            prod_vld  <= 1'b0;
            state     <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Sample history: the accepted sample lands at wp and is the k=0 term.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_TAPS); i++) hist[i] <= '0;
    end else if (accept) begin
      hist[wp] <= x_in;
    end
  end

  // Coefficient bank: writes only land while idle and in range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_TAPS); i++) h[i] <= '0;
    end else if (coef_we && (state == StIdle) && ({1'b0, coef_addr} < NT)) begin
      h[coef_addr] <= coef_data;
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Scoreboard bench for fir_serial_mac: two 8-tap instances share all inputs,
// one with OUT_SHIFT=0 and one with OUT_SHIFT=31.
module tb_fir_serial_mac;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic coef_we = 1'b0;
  logic signed [31:0] x_in = '0;
  logic signed [31:0] coef_data = '0;
  logic [2:0] coef_addr = '0;

  logic in_ready_a, out_valid_a, busy_a;
  logic in_ready_b, out_valid_b, busy_b;
  logic signed [31:0] y_a, y_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic signed [31:0] exp_a[$];
  logic signed [31:0] exp_b[$];
  int acc_cyc[$];

  logic signed [31:0] m_h[N];
  logic signed [31:0] m_hist[N];
  int m_wp = 0;
  logic prev_v = 1'b0;

  fir_serial_mac #(.N_TAPS(N), .ACC_W(72), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .x_in(x_in),
    .out_valid(out_valid_a), .out_ready(out_ready), .y_out(y_a), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_a)
  );

  fir_serial_mac #(.N_TAPS(N), .ACC_W(72), .OUT_SHIFT(31)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .x_in(x_in),
    .out_valid(out_valid_b), .out_ready(out_ready), .y_out(y_b), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direct-form reference over the bench's own history copy.
  function automatic logic signed [31:0] model(input int base, input int shamt);
    logic signed [127:0] acc;
    logic signed [63:0] p;
    acc = '0;
    for (int k = 0; k < N; k++) begin
      p = 64'(m_h[k]) * 64'(m_hist[(base - k + N) % N]);
      acc = acc + 128'(p);
    end
    acc = acc >>> shamt;
    if (acc > 128'sd2147483647) return 32'sh7fff_ffff;
    if (acc < -128'sd2147483648) return 32'sh8000_0000;
    return acc[31:0];
  endfunction

  // Monitor: latency on the rising edge of out_valid, value on each handshake.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid_a && !prev_v) begin
        if (acc_cyc.size() == 0) begin
          checks++; errors++;
          $display("FAIL latency: got out_valid with no pending accept expected none");
        end else begin
          chk("latency", cyc - acc_cyc.pop_front(), N + 1);
        end
      end
      prev_v = out_valid_a;
      if (out_valid_a && out_ready) begin
        if (exp_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL y_out_a: got %0d expected no output", y_a);
        end else begin
          chk("y_out_a", y_a, exp_a.pop_front());
        end
      end
      if (out_valid_b && out_ready) begin
        if (exp_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL y_out_b: got %0d expected no output", y_b);
        end else begin
          chk("y_out_b", y_b, exp_b.pop_front());
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_h[i] = '0;
      m_hist[i] = '0;
    end
    m_wp = 0;
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic signed [31:0] d);
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    if (!busy_a) m_h[a] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // mode 0: no result expected, 1: hand-computed e0/e31, 2: reference model
  task automatic send(input logic signed [31:0] x, input int mode,
                      input logic signed [31:0] e0, input logic signed [31:0] e31,
                      input logic cw, input logic [2:0] ca, input logic signed [31:0] cd);
    int n = 0;
    int base;
    @(negedge clk);
    in_valid = 1'b1;
    x_in = x;
    coef_we = cw;
    coef_addr = ca;
    coef_data = cd;
    while (!in_ready_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      in_valid = 1'b0;
      coef_we = 1'b0;
      return;
    end
    if (cw) m_h[ca] = cd;
    base = m_wp;
    m_hist[m_wp] = x;
    m_wp = (m_wp + 1) % N;
    if (mode == 1) begin
      exp_a.push_back(e0);
      exp_b.push_back(e31);
    end else if (mode == 2) begin
      exp_a.push_back(model(base, 0));
      exp_b.push_back(model(base, 31));
    end
    @(posedge clk);
    #1;
    if (mode != 0) acc_cyc.push_back(cyc);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_a.size() != 0 || !in_ready_a) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_a.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc[8] = '{3, -7, 11, -13, -13, 11, -7, 3};
    logic signed [31:0] y0;
    logic signed [31:0] xr;
    int n;

    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_y_out", y_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_y_out_b", y_b, 0);
    reset = 1'b0;

    // Impulse response: h = 1..8, x = 1,0,0,... gives y = 1..8
    for (int k = 0; k < N; k++) wr_coef(3'(k), 32'(k + 1));
    for (int i = 0; i < N; i++) send((i == 0) ? 32'sd1 : 32'sd0, 1, 32'(i + 1), 0, 0, 0, 0);
    wait_idle();

    // Reset mid-MAC discards the computation and clears history and coefficients
    send(32'sd1234, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("busy_mid_mac", busy_a, 1);
    reset = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready_a, 1);
    chk("rst2_out_valid", out_valid_a, 0);
    chk("rst2_y_out", y_a, 0);
    chk("rst2_busy", busy_a, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    acc_cyc.delete();
    for (int k = 0; k < N; k++) wr_coef(3'(k), 32'(k + 1));
    send(32'sd7, 1, 32'sd7, 0, 0, 0, 0);
    wait_idle();

    // Saturation at both ends, and the shift-by-31 case
    wr_coef(0, 32'sh7fff_ffff);
    for (int k = 1; k < N; k++) wr_coef(3'(k), 0);
    send(32'sh7fff_ffff, 1, 32'sh7fff_ffff, 32'sh7fff_fffe, 0, 0, 0);
    send(32'sh8000_0000, 1, 32'sh8000_0000, 32'sh8000_0001, 0, 0, 0);
    wait_idle();

    // Coefficient write while busy is dropped; write with accept is used at once
    wr_coef(0, 32'sd3);
    send(32'sd10, 1, 32'sd30, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("busy_for_write", busy_a, 1);
    wr_coef(0, 32'sd5);
    wait_idle();
    send(32'sd10, 1, 32'sd50, 0, 1, 0, 32'sd5);
    wait_idle();

    // Backpressure: history 10 at index 4, new sample 4 at index 5 -> 5*4 + 1*10
    wr_coef(1, 32'sd1);
    out_ready = 1'b0;
    send(32'sd4, 1, 32'sd30, 0, 0, 0, 0);
    n = 0;
    while (!out_valid_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid_a, 1);
    y0 = y_a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = (i % 3 == 0);
      x_in = 32'sd999;
      chk("bp_y_stable", y_a, y0);
      chk("bp_in_ready", in_ready_a, 0);
    end
    chk("bp_valid_held", out_valid_a, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("idle_after_hs", in_ready_a, 1);
    chk("valid_drop_after_hs", out_valid_a, 0);
    // Ignored pulses must not have entered history: 5*6 + 1*4
    send(32'sd6, 1, 32'sd34, 0, 0, 0, 0);
    wait_idle();

    // Symmetric taps, mixed-range samples against the reference model
    for (int k = 0; k < N; k++) wr_coef(3'(k), 32'(rc[k]));
    for (int i = 0; i < 24; i++) begin
      if (i % 5 == 4) xr = $urandom();
      else xr = 32'($urandom_range(0, 65535)) - 32'sd32768;
      send(xr, 2, 0, 0, 0, 0, 0);
    end
    wait_idle();
    chk("queue_a_empty", exp_a.size(), 0);
    chk("queue_b_empty", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
